// File: rtl/ysyx_24110006_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110006_mem_arbiter_if
// Description : Bundle of every request/response signal around the memory
//               arbiter.
//               - IFU read channel: valid/ready/addr, then rvalid/rdata/err.
//               - LSU read/write channel: valid/ready/addr/wen/wdata/wmask,
//                 then rvalid/rdata/err.
//               - Shared memory channel: valid/ready/addr/wen/wdata/wmask,
//                 then rvalid/rdata/err.
//               - o_busy: a transaction is in flight.
//               Modports:
//               - slave  : the arbiter's view.
//               - master : the view of the surrounding requesters and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_24110006_mem_arbiter_if;
  // IFU request / response
  logic        i_ifu_valid;
  logic        o_ifu_ready;
  logic [31:0] i_ifu_addr;
  logic        o_ifu_rvalid;
  logic [31:0] o_ifu_rdata;
  logic        o_ifu_err;
  // LSU request / response
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wen;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wmask;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_err;
  // Shared memory request / response
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_err;
  // Status
  logic        o_busy;

  modport slave (
    input  i_ifu_valid, i_ifu_addr,
    output o_ifu_ready, o_ifu_rvalid, o_ifu_rdata, o_ifu_err,
    input  i_lsu_valid, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wmask,
    output o_lsu_ready, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err,
    output o_busy
  );

  modport master (
    output i_ifu_valid, i_ifu_addr,
    input  o_ifu_ready, o_ifu_rvalid, o_ifu_rdata, o_ifu_err,
    output i_lsu_valid, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wmask,
    input  o_lsu_ready, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err,
    input  o_busy
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_24110006_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110006_mem_arbiter
// Description : Two-requester (IFU, LSU) arbiter in front of one memory port.
//               One transaction is outstanding at a time: IDLE -> REQ -> RESP.
//               The LSU wins ties, except after STARVE_LIMIT consecutive LSU
//               grants taken while the IFU was waiting, when the IFU wins.
// Ports       : i_clock - rising-edge clock
//               i_reset - asynchronous active-low reset
//               bus     - ysyx_24110006_mem_arbiter_if.slave (IFU, LSU and
//                         memory channels plus o_busy)
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24110006_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input wire                            i_clock,
  input wire                            i_reset,
  ysyx_24110006_mem_arbiter_if.slave    bus
);

  // Counter must hold 0..STARVE_LIMIT; keep at least one bit for LIMIT=0.
  localparam int unsigned C_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;     // 0 = IFU, 1 = LSU
  logic [C_CNT_W-1:0]  starve_q, starve_d;
  logic [31:0]         addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wmask_q, wmask_d;

  logic w_idle, w_resp, w_starved, w_lsu_win, w_ifu_win;

  assign w_idle    = (state_q == IDLE);
  assign w_resp    = (state_q == RESP);
  assign w_starved = (starve_q == C_LIMIT);
  // Winner is only defined in IDLE, so ready never leaks into REQ/RESP.
  assign w_lsu_win = w_idle & bus.i_lsu_valid & ~(bus.i_ifu_valid & w_starved);
  assign w_ifu_win = w_idle & bus.i_ifu_valid & ~w_lsu_win;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    case (state_q)
      IDLE: begin
        if (w_lsu_win) begin
          state_d = REQ;
          owner_d = 1'b1;
          addr_d  = bus.i_lsu_addr;
          wen_d   = bus.i_lsu_wen;
          wdata_d = bus.i_lsu_wdata;
          wmask_d = bus.i_lsu_wmask;
          // Only grants that made the IFU wait count towards starvation.
          if (bus.i_ifu_valid && !w_starved) begin
            starve_d = starve_q + C_CNT_W'(1);
          end
        end else if (w_ifu_win) begin
          state_d  = REQ;
          owner_d  = 1'b0;
          addr_d   = bus.i_ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = 32'd0;
          wmask_d  = 4'd0;
          starve_d = '0;
        end
      end
      REQ: begin
        if (bus.i_mem_ready) state_d = RESP;
      end
      RESP: begin
        if (bus.i_mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      addr_q   <= 32'd0;
      wen_q    <= 1'b0;
      wdata_q  <= 32'd0;
      wmask_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

  assign bus.o_ifu_ready  = w_ifu_win;
  assign bus.o_lsu_ready  = w_lsu_win;

  assign bus.o_mem_valid  = (state_q == REQ);
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_wen    = wen_q;
  assign bus.o_mem_wdata  = wdata_q;
  assign bus.o_mem_wmask  = wmask_q;

  // Responses are steered to the owner only in RESP; everything else is 0.
  assign bus.o_ifu_rvalid = w_resp & ~owner_q & bus.i_mem_rvalid;
  assign bus.o_ifu_rdata  = (w_resp & ~owner_q) ? bus.i_mem_rdata : 32'd0;
  assign bus.o_ifu_err    = w_resp & ~owner_q & bus.i_mem_err;
  assign bus.o_lsu_rvalid = w_resp & owner_q & bus.i_mem_rvalid;
  assign bus.o_lsu_rdata  = (w_resp & owner_q) ? bus.i_mem_rdata : 32'd0;
  assign bus.o_lsu_err    = w_resp & owner_q & bus.i_mem_err;

  assign bus.o_busy       = ~w_idle;

endmodule
`default_nettype wire
